// File: rtl/watch_chain_reader.sv
// Host-side master for the CPU debug watch scan chain: issues one capture pulse,
// then WIDTH recirculating shift pulses, and deserialises the chain output into oData.
module watch_chain_reader #(
  parameter int WIDTH    = 348,
  parameter int DIV_HALF = 2
) (
  input  logic             iCPU_Clk,
  input  logic             iCPU_Reset,
  input  logic             iStart,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oScanClk,
  output logic [1:0]       oScanCtrl,
  output logic             oScanIn,
  input  logic             iScanOut
);

  // state     | meaning
  // S_IDLE    | scan clock parked low, waiting for iStart
  // S_CAPTURE | one scan pulse with CaptureDR asserted
  // S_SHIFT   | WIDTH scan pulses with ShiftDR, output bit recirculated into the chain
  // S_DONE    | one cycle: publish shadow word, pulse oDone

  localparam int BW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (DIV_HALF > 1) ? $clog2(2 * DIV_HALF) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV_HALF - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(DIV_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(DIV_HALF);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              sin_q, sin_d;
  logic              active;

  always_ff @(posedge iCPU_Clk) begin
    if (!iCPU_Reset) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      ctrl_q   <= 2'b00;
      sin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      ctrl_q   <= ctrl_d;
      sin_q    <= sin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_CAPTURE;
          ph_d    = '0;
          bit_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (ph_q == PH_LAST) begin
          state_d = S_SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so control and data only move
  // on the edge that starts a low phase of the scan clock.
  always_comb begin
    active   = (state_d == S_CAPTURE) || (state_d == S_SHIFT);
    busy_d   = active;
    done_d   = (state_d == S_DONE);
    sclk_d   = active && (ph_d >= PH_HIGH);
    ctrl_d   = 2'b00;
    if (state_d == S_CAPTURE) ctrl_d = 2'b01;
    if (state_d == S_SHIFT)   ctrl_d = 2'b10;

    sin_d = sin_q;
    if (state_d != S_SHIFT) begin
      sin_d = 1'b0;
    end else if (ph_d == '0) begin
      sin_d = iScanOut;
    end

    idx      = bit_q[IW-1:0];
    shadow_d = shadow_q;
    if ((state_q == S_SHIFT) && (ph_q == PH_RISE)) begin
      shadow_d[idx] = iScanOut;
    end

    data_d = data_q;
    if (state_d == S_DONE) data_d = shadow_q;
  end

  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oData     = data_q;
  assign oScanClk  = sclk_q;
  assign oScanCtrl = ctrl_q;
  assign oScanIn   = sin_q;

endmodule

// File: tb/tb_watch_chain_reader.sv
// Scoreboard bench for watch_chain_reader: three instances (8/1, 8/3, 348/2), each
// driving a behavioural recirculating scan chain.
module tb_watch_chain_reader;

  typedef struct {
    logic [347:0] d;
    int           cyc;
  } exp_t;

  bit   clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [3];
  logic busy [3], done [3], sclk [3], sin [3], sout [3];
  logic [1:0] ctrl [3];
  logic [7:0]   data0, data1;
  logic [347:0] data2;
  logic [7:0]   chain0 = '0, chain1 = '0, par0 = '0, par1 = '0;
  logic [347:0] chain2 = '0, par2 = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rst_seen = 1'b1;
  exp_t q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !rst_n;

  watch_chain_reader #(.WIDTH(8), .DIV_HALF(1)) u0 (
    .iCPU_Clk(clk), .iCPU_Reset(rst_n), .iStart(st[0]), .oBusy(busy[0]), .oDone(done[0]),
    .oData(data0), .oScanClk(sclk[0]), .oScanCtrl(ctrl[0]), .oScanIn(sin[0]), .iScanOut(sout[0]));
  watch_chain_reader #(.WIDTH(8), .DIV_HALF(3)) u1 (
    .iCPU_Clk(clk), .iCPU_Reset(rst_n), .iStart(st[1]), .oBusy(busy[1]), .oDone(done[1]),
    .oData(data1), .oScanClk(sclk[1]), .oScanCtrl(ctrl[1]), .oScanIn(sin[1]), .iScanOut(sout[1]));
  watch_chain_reader #(.WIDTH(348), .DIV_HALF(2)) u2 (
    .iCPU_Clk(clk), .iCPU_Reset(rst_n), .iStart(st[2]), .oBusy(busy[2]), .oDone(done[2]),
    .oData(data2), .oScanClk(sclk[2]), .oScanCtrl(ctrl[2]), .oScanIn(sin[2]), .iScanOut(sout[2]));

  // Behavioural chains: capture on ctrl=01, shift right with oScanIn into the MSB on ctrl=10.
  always @(posedge sclk[0])
    if (ctrl[0] == 2'b01) chain0 <= par0;
    else if (ctrl[0] == 2'b10) chain0 <= {sin[0], chain0[7:1]};
  always @(posedge sclk[1])
    if (ctrl[1] == 2'b01) chain1 <= par1;
    else if (ctrl[1] == 2'b10) chain1 <= {sin[1], chain1[7:1]};
  always @(posedge sclk[2])
    if (ctrl[2] == 2'b01) chain2 <= par2;
    else if (ctrl[2] == 2'b10) chain2 <= {sin[2], chain2[347:1]};
  assign sout[0] = chain0[0];
  assign sout[1] = chain1[0];
  assign sout[2] = chain2[0];

  function automatic int w_of(int k);
    return (k == 2) ? 348 : 8;
  endfunction

  function automatic int n_of(int k);
    case (k)
      0:       return 18;
      1:       return 54;
      default: return 1396;
    endcase
  endfunction

  function automatic logic [347:0] get_data(int k);
    case (k)
      0:       return {340'b0, data0};
      1:       return {340'b0, data1};
      default: return data2;
    endcase
  endfunction

  function automatic logic [347:0] get_chain(int k);
    case (k)
      0:       return {340'b0, chain0};
      1:       return {340'b0, chain1};
      default: return chain2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [347:0] act, input logic [347:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations on oDone and checks timing, data, chain restore and pulse counts.
  logic [347:0] prev_data [3];
  logic         psclk [3], psin [3];
  logic [1:0]   pctrl [3];
  int           bcnt [3], ncap [3], nshf [3];

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_seen) begin
        bcnt[k] = 0; ncap[k] = 0; nshf[k] = 0;
      end else begin
        if (sclk[k] === 1'b1)
          chk($sformatf("u%0d_ctrl_stable_while_sclk_high", k),
              {345'b0, ctrl[k], sin[k]}, {345'b0, pctrl[k], psin[k]});
        if (sclk[k] === 1'b1 && psclk[k] === 1'b0) begin
          if (ctrl[k] == 2'b01) ncap[k]++;
          else if (ctrl[k] == 2'b10) nshf[k]++;
        end
        if (busy[k] === 1'b1) bcnt[k]++;
        if (done[k] === 1'b1) begin
          if (q[k].size() == 0) begin
            chk($sformatf("u%0d_unexpected_done", k), 348'd1, 348'd0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("u%0d_data", k), get_data(k), e.d);
            chk($sformatf("u%0d_done_cycle", k), 348'(cyc), 348'(e.cyc));
            chk($sformatf("u%0d_chain_restored", k), get_chain(k), e.d);
            chk($sformatf("u%0d_capture_pulses", k), 348'(ncap[k]), 348'd1);
            chk($sformatf("u%0d_shift_pulses", k), 348'(nshf[k]), 348'(w_of(k)));
            chk($sformatf("u%0d_busy_cycles", k), 348'(bcnt[k]), 348'(n_of(k)));
            chk($sformatf("u%0d_busy_in_done", k), 348'(busy[k]), 348'd0);
          end
          bcnt[k] = 0; ncap[k] = 0; nshf[k] = 0;
        end else begin
          chk($sformatf("u%0d_data_hold", k), get_data(k), prev_data[k]);
          if (busy[k] !== 1'b1) begin
            bcnt[k] = 0; ncap[k] = 0; nshf[k] = 0;
          end
        end
      end
      prev_data[k] = get_data(k);
      psclk[k] = sclk[k];
      pctrl[k] = ctrl[k];
      psin[k]  = sin[k];
    end
  end

  task automatic start(input int k, input logic [347:0] d, output int t);
    exp_t e;
    @(negedge clk);
    st[k] = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    e.d = d;
    e.cyc = t + n_of(k);
    q[k].push_back(e);
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  task automatic wait_empty(input int k);
    for (int i = 0; i < 3000 && q[k].size() != 0; i++) @(negedge clk);
    if (q[k].size() != 0) chk($sformatf("u%0d_timeout", k), 348'(q[k].size()), 348'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    exp_t e;
    logic [347:0] v;
    for (int k = 0; k < 3; k++) st[k] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_busy", k), 348'(busy[k]), 348'd0);
      chk($sformatf("u%0d_rst_done", k), 348'(done[k]), 348'd0);
      chk($sformatf("u%0d_rst_sclk", k), 348'(sclk[k]), 348'd0);
      chk($sformatf("u%0d_rst_ctrl", k), 348'(ctrl[k]), 348'd0);
      chk($sformatf("u%0d_rst_sin", k), 348'(sin[k]), 348'd0);
      chk($sformatf("u%0d_rst_data", k), get_data(k), 348'd0);
    end
    rst_n = 1'b1;

    // Single snapshot, then a second with new chain contents and iStart during DONE.
    par0 = 8'hA5;
    start(0, 348'hA5, t);
    wait_empty(0);
    par0 = 8'h3C;
    start(0, 348'h3C, t);
    while (cyc < t + 18) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_empty(0);
    repeat (30) @(negedge clk);

    // iStart held high: back-to-back snapshots with one idle cycle between.
    par0 = 8'h5A;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    e.d = 348'h5A; e.cyc = t + 18; q[0].push_back(e);
    e.d = 348'h5A; e.cyc = t + 38; q[0].push_back(e);
    repeat (29) @(negedge clk);
    st[0] = 1'b0;
    wait_empty(0);
    repeat (30) @(negedge clk);

    // Slow scan clock with iStart re-asserted mid-snapshot.
    par1 = 8'hC3;
    start(1, 348'hC3, t);
    while (cyc < t + 5) @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    wait_empty(1);
    repeat (80) @(negedge clk);

    // Reset during a snapshot aborts it and clears oData.
    par0 = 8'h0F;
    start(0, 348'h0F, t);
    while (cyc < t + 7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 348'(busy[0]), 348'd0);
    chk("abort_done", 348'(done[0]), 348'd0);
    chk("abort_sclk", 348'(sclk[0]), 348'd0);
    chk("abort_ctrl", 348'(ctrl[0]), 348'd0);
    chk("abort_data", get_data(0), 348'd0);
    q[0].delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    par0 = 8'hF0;
    start(0, 348'hF0, t);
    wait_empty(0);
    repeat (30) @(negedge clk);

    // Full-width chain: walking ones at both ends plus a sparse pattern.
    v = '0; v[0] = 1'b1;
    par2 = v;
    start(2, v, t);
    wait_empty(2);
    v = '0; v[347] = 1'b1;
    par2 = v;
    start(2, v, t);
    wait_empty(2);
    v = '0;
    for (int i = 0; i < 348; i++) if ((i % 7) == 0) v[i] = 1'b1;
    par2 = v;
    start(2, v, t);
    wait_empty(2);

    repeat (50) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d_queue_drained", k), 348'(q[k].size()), 348'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
